spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/spike_encoder_if.sv | 48 ++++
 rtl/spike_encoder.sv | 160 ++++++++++++++++
 tb/tb_spike_encoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_encoder_if.sv
// spike_encoder_if
//   Bundles the spike-vector input handshake, the address output handshake
//   and the timestep flush signals of the spike encoder.
//   Optional macro: SPIKE_ENCODER_COUNT_EN adds spike_count (16 bit).
// Signals:
//   spike_vec      [NUM_NEURONS] fired-neuron bitmap from the neuron array
//   spike_valid    spike_vec is offered this cycle
//   spike_ready    encoder FIFO can take a vector
//   source_address [12] address of the spiking neuron
//   addr_valid     source_address carries a spike
//   out_ready      downstream takes source_address this cycle
//   timestep_end   pulse: no more vectors for this timestep
//   flush_done     pulse: every spike of the timestep has been sent
//   spike_count    [16] (macro only) handshakes in the current timestep
// Modports: master = producer/consumer side, slave = encoder side.
interface spike_encoder_if #(
    parameter int NUM_NEURONS = 10
);
    logic [NUM_NEURONS-1:0] spike_vec;
    logic                   spike_valid;
    logic                   spike_ready;
    logic [11:0]            source_address;
    logic                   addr_valid;
    logic                   out_ready;
    logic                   timestep_end;
    logic                   flush_done;
`ifdef SPIKE_ENCODER_COUNT_EN
    logic [15:0]            spike_count;

    modport master (
        output spike_vec, spike_valid, out_ready, timestep_end,
        input  spike_ready, source_address, addr_valid, flush_done, spike_count
    );
    modport slave (
        input  spike_vec, spike_valid, out_ready, timestep_end,
        output spike_ready, source_address, addr_valid, flush_done, spike_count
    );
`else
    modport master (
        output spike_vec, spike_valid, out_ready, timestep_end,
        input  spike_ready, source_address, addr_valid, flush_done
    );
    modport slave (
        input  spike_vec, spike_valid, out_ready, timestep_end,
        output spike_ready, source_address, addr_valid, flush_done
    );
`endif
endinterface

// File: rtl/spike_encoder.sv
// spike_encoder
//   Buffers fired-neuron bitmaps in a small FIFO and serialises each one into
//   a stream of neuron addresses (lowest index first), one per cycle at full
//   throughput. A timestep_end pulse arms a flush; flush_done pulses once the
//   encoder is idle with nothing buffered.
//   Optional macro: SPIKE_ENCODER_COUNT_EN adds a saturating 16-bit count of
//   address handshakes, cleared after flush_done.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  spike_encoder_if.slave (see interface header for signal list)
// Parameters:
//   NUM_NEURONS   bitmap width
//   BASE_ADDRESS  address of neuron 0 (addresses wrap modulo 4096)
//   FIFO_DEPTH    buffered vectors, power of two, at least 2
//   IDLE_ADDRESS  source_address value while addr_valid is low
module spike_encoder #(
    parameter int          NUM_NEURONS  = 10,
    parameter logic [11:0] BASE_ADDRESS = 12'd0,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [11:0] IDLE_ADDRESS = 12'hFFF
) (
    input logic             clk,
    input logic             rst,
    spike_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [NUM_NEURONS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       occ;
    logic [NUM_NEURONS-1:0] cur;
    logic [NUM_NEURONS-1:0] cur_cleared;
    logic [NUM_NEURONS-1:0] cur_next;
    logic                   flush_pending;
    logic                   addr_valid;
    logic [11:0]            source_address;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   hs;
    logic                   flush_done;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [11:0] lowest_index(input logic [NUM_NEURONS-1:0] v);
        logic [11:0] idx;
        idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) idx = 12'(i);
        end
        return idx;
    endfunction

    assign full  = (occ == CNT_W'(FIFO_DEPTH));
    assign empty = (occ == '0);

    // Ready looks only at occupancy so it never depends on out_ready.
    assign bus.spike_ready = !full;

    // All-zero vectors are accepted but never stored.
    assign push = bus.spike_valid && !full && (|bus.spike_vec);
    assign hs   = addr_valid && bus.out_ready;

    // cur with its lowest set bit removed.
    assign cur_cleared = cur & (cur - NUM_NEURONS'(1));

    // Load a new vector either from IDLE or directly behind the last spike
    // of the current one, so back-to-back vectors leave no bubble.
    assign pop = !empty && ((state == IDLE) || (hs && (cur_cleared == '0)));

    always_comb begin
        cur_next = cur;
        if (pop) begin
            cur_next = mem[rd_ptr];
        end else if (hs) begin
            cur_next = cur_cleared;
        end
    end

    assign flush_done = flush_pending && (state == IDLE) && empty && !push;

    // Vector storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.spike_vec;
    end

    // Address outputs are registered from cur_next so they never follow an
    // input combinationally and hold while out_ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cur            <= '0;
            addr_valid     <= 1'b0;
            source_address <= IDLE_ADDRESS;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            flush_pending  <= 1'b0;
        end else begin
            cur <= cur_next;
            if (cur_next != '0) begin
                state          <= SEND;
                addr_valid     <= 1'b1;
                source_address <= BASE_ADDRESS + lowest_index(cur_next);
            end else begin
                state          <= IDLE;
                addr_valid     <= 1'b0;
                source_address <= IDLE_ADDRESS;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                occ <= occ + CNT_W'(1);
            end else if (pop && !push) begin
                occ <= occ - CNT_W'(1);
            end
            // A timestep_end coinciding with flush_done merges into that flush.
            if (flush_done) begin
                flush_pending <= 1'b0;
            end else if (bus.timestep_end) begin
                flush_pending <= 1'b1;
            end
        end
    end

    assign bus.addr_valid     = addr_valid;
    assign bus.source_address = source_address;
    assign bus.flush_done     = flush_done;

`ifdef SPIKE_ENCODER_COUNT_EN
    logic [15:0] spike_count;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Holds its final value through the flush_done cycle, clears after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_count <= '0;
        end else if (flush_done) begin
            spike_count <= '0;
        end else if (hs) begin
            spike_count <= sat_inc(spike_count);
        end
    end

    assign bus.spike_count = spike_count;
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder
//   Bench for spike_encoder (NUM_NEURONS=10, BASE_ADDRESS=4, FIFO_DEPTH=4).
//   A queue-based reference model tracks buffered vectors and the vector in
//   service; a compare process checks every output each cycle, directed
//   sequences pin hand-computed values, then a randomized phase follows.
//   Honors SPIKE_ENCODER_COUNT_EN for the spike_count output.
module tb_spike_encoder;
    localparam int N     = 10;
    localparam int BASE  = 4;
    localparam int DEPTH = 4;
    localparam int IDLEA = 12'hFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    spike_encoder_if #(.NUM_NEURONS(N)) bus ();

    spike_encoder #(
        .NUM_NEURONS (N),
        .BASE_ADDRESS(12'(BASE)),
        .FIFO_DEPTH  (DEPTH),
        .IDLE_ADDRESS(12'hFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, $time, got, got, exp, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    logic [N-1:0] mq [$];
    logic [N-1:0] mcur = '0;
    bit           mpend = 1'b0;
    int           mcount = 0;
    bit           m_push, m_done, m_hs;

    function automatic bit exp_push();
        return bus.spike_valid && (mq.size() < DEPTH) && (bus.spike_vec != '0);
    endfunction

    function automatic bit exp_done();
        return mpend && (mcur == '0) && (mq.size() == 0) && !exp_push();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mcur   = '0;
            mpend  = 1'b0;
            mcount = 0;
        end else begin
            m_push = exp_push();
            m_done = exp_done();
            m_hs   = (mcur != '0) && bus.out_ready;
            if (m_hs) mcur[lowest(mcur)] = 1'b0;
            if (mcur == '0 && mq.size() > 0) mcur = mq.pop_front();
            if (m_push) mq.push_back(bus.spike_vec);
            if (m_done) begin
                mcount = 0;
                mpend  = 1'b0;
            end else begin
                if (m_hs && mcount < 65535) mcount++;
                if (bus.timestep_end) mpend = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("addr_valid", int'(bus.addr_valid), int'(mcur != '0));
            chk("source_address", int'(bus.source_address),
                (mcur != '0) ? ((BASE + lowest(mcur)) % 4096) : IDLEA);
            chk("spike_ready", int'(bus.spike_ready), int'(mq.size() < DEPTH));
            chk("flush_done", int'(bus.flush_done), int'(exp_done()));
`ifdef SPIKE_ENCODER_COUNT_EN
            chk("spike_count", int'(bus.spike_count), mcount);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.spike_vec    = '0;
        bus.spike_valid  = 1'b0;
        bus.out_ready    = 1'b1;
        bus.timestep_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_a [4];
        logic [N-1:0] v;

        idle_inputs();
        rst = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst addr_valid", int'(bus.addr_valid), 0);
        chk("rst source_address", int'(bus.source_address), 12'hFFF);
        chk("rst spike_ready", int'(bus.spike_ready), 1);
        chk("rst flush_done", int'(bus.flush_done), 0);
`ifdef SPIKE_ENCODER_COUNT_EN
        chk("rst spike_count", int'(bus.spike_count), 0);
`endif
        tick();
        rst = 1'b0;

        // Single vector: addresses 4,6,9 from t+2, then idle.
        bus.spike_vec = 10'b0000100101; bus.spike_valid = 1'b1;
        tick();
        idle_inputs();
        exp_a = '{4, 6, 9, 12'hFFF};
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("seq addr", int'(bus.source_address), exp_a[i]);
            chk("seq valid", int'(bus.addr_valid), (i < 3) ? 1 : 0);
        end
        repeat (2) tick();

        // Backpressure: address 6 held three cycles, next vector waits.
        bus.spike_vec = 10'b0000100101; bus.spike_valid = 1'b1;
        tick();
        bus.spike_vec = 10'b1000000000;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("bp addr4", int'(bus.source_address), 4);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp hold", int'(bus.source_address), 6);
            chk("bp hold valid", int'(bus.addr_valid), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release", int'(bus.source_address), 6);
        tick();
        @(negedge clk);
        chk("bp after", int'(bus.source_address), 9);
        tick();
        @(negedge clk);
        chk("bp next vec", int'(bus.source_address), 13);
        repeat (3) tick();

        // FIFO fill: one vector in service plus four buffered.
        bus.out_ready = 1'b0;
        bus.spike_valid = 1'b1;
        bus.spike_vec = 10'b0000000011; tick();
        bus.spike_vec = 10'b0000110000; tick();
        bus.spike_vec = 10'b1100000000; tick();
        bus.spike_vec = 10'b0001000000; tick();
        bus.spike_vec = 10'b0010000100; tick();
        bus.spike_vec = 10'b0101010101;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full ready c5", int'(bus.spike_ready), 0);
        tick();
        @(negedge clk);
        chk("full ready c6", int'(bus.spike_ready), 0);
        tick();
        @(negedge clk);
        chk("full ready c7", int'(bus.spike_ready), 1);
        tick();
        idle_inputs();
        repeat (60) tick();

        // Flush after two vectors (3 + 2 spikes).
        do_reset();
        bus.spike_vec = 10'b0000010101; bus.spike_valid = 1'b1;
        tick();
        bus.spike_vec = 10'b1000000001;
        tick();
        idle_inputs();
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("flush c6", int'(bus.flush_done), 0);
        chk("flush c6 last addr", int'(bus.source_address), 13);
        tick();
        @(negedge clk);
        chk("flush c7", int'(bus.flush_done), 1);
`ifdef SPIKE_ENCODER_COUNT_EN
        chk("count at flush", int'(bus.spike_count), 5);
`endif
        tick();
        @(negedge clk);
        chk("flush c8", int'(bus.flush_done), 0);
`ifdef SPIKE_ENCODER_COUNT_EN
        chk("count after flush", int'(bus.spike_count), 0);
`endif
        tick();

        // Reset while the second of three spikes is on the bus.
        bus.spike_vec = 10'b0000000111; bus.spike_valid = 1'b1;
        tick();
        idle_inputs();
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        tick();
        @(negedge clk);
        chk("rst mid addr", int'(bus.source_address), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst mid valid", int'(bus.addr_valid), 0);
        chk("rst mid source", int'(bus.source_address), 12'hFFF);
        chk("rst mid ready", int'(bus.spike_ready), 1);
        chk("rst mid flush", int'(bus.flush_done), 0);
        tick();
        @(negedge clk);
        chk("rst mid flush2", int'(bus.flush_done), 0);
        tick();

        // All-zero vector then timestep_end.
        bus.spike_vec = '0; bus.spike_valid = 1'b1;
        tick();
        idle_inputs();
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        @(negedge clk);
        chk("zero flush", int'(bus.flush_done), 1);
        chk("zero valid", int'(bus.addr_valid), 0);
        tick();
        @(negedge clk);
        chk("zero flush2", int'(bus.flush_done), 0);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            v = N'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) v = '0;
            bus.spike_vec    = v;
            bus.spike_valid  = ($urandom_range(0, 1) == 1);
            bus.out_ready    = ($urandom_range(0, 9) < 7);
            bus.timestep_end = ($urandom_range(0, 19) == 0);
            rst              = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (60) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
